// File: rtl/dna_pkg.sv
// Shared constants, state encoding and the masked ID compare for the device-DNA reader.
package dna_pkg;

  localparam int DNA_BITS = 96;
  localparam int CNT_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SH   = 2'd2
  } dna_state_t;

  function automatic logic dna_match(input logic [DNA_BITS-1:0] value,
                                     input logic [DNA_BITS-1:0] ref_val,
                                     input logic [DNA_BITS-1:0] mask);
    return ((value ^ ref_val) & mask) == '0;
  endfunction

endpackage

// File: rtl/dna_reader_ctrl_if.sv
// Control/status and DNA_PORTE2-facing signals of the device-DNA reader.
interface dna_reader_ctrl_if;
  import dna_pkg::*;

  logic                START;
  logic                BUSY;
  logic                DONE;
  logic                DNA_VALID;
  logic [DNA_BITS-1:0] DNA_VALUE;
  logic                DNA_MATCH;
  logic                DNA_READ;
  logic                DNA_SHIFT;
  logic                DNA_DIN;
  logic                DNA_DOUT;

  modport master (
    output START, DNA_DOUT,
    input  BUSY, DONE, DNA_VALID, DNA_VALUE, DNA_MATCH, DNA_READ, DNA_SHIFT, DNA_DIN
  );

  modport slave (
    input  START, DNA_DOUT,
    output BUSY, DONE, DNA_VALID, DNA_VALUE, DNA_MATCH, DNA_READ, DNA_SHIFT, DNA_DIN
  );

endinterface

// File: rtl/dna_shift_capture.sv
// LSB-first deserializer with bit counter; cap already includes the bit currently on din.
module dna_shift_capture
  import dna_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                din,
  output logic [DNA_BITS-1:0] cap,
  output logic                last
);

  // Only 95 bits are stored: the final bit is taken straight from din on the last shift.
  logic [DNA_BITS-2:0] sr;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= cap[DNA_BITS-1:1];
      cnt <= cnt + 1'b1;
    end
  end

  assign cap  = {din, sr};
  assign last = shift_en && (cnt == CNT_W'(DNA_BITS - 1));

endmodule

// File: rtl/dna_reader_ctrl.sv
// Sequencer for the DNA_PORTE2 primitive: one READ pulse, 96 SHIFT cycles, parallel result.
//
//  state | meaning
//  IDLE  | waiting for START or the post-reset auto read
//  RD    | DNA_READ high for one cycle, primitive loads its DNA
//  SH    | DNA_SHIFT high, one DOUT bit captured per cycle
module dna_reader_ctrl
  import dna_pkg::*;
#(
  parameter bit                  AUTO_START   = 1'b1,
  parameter logic [DNA_BITS-1:0] EXPECTED_DNA = '0,
  parameter logic [DNA_BITS-1:0] MATCH_MASK   = '0
) (
  input logic              CLK,
  input logic              RST,
  dna_reader_ctrl_if.slave bus
);

  dna_state_t          state;
  logic                pend;
  logic [DNA_BITS-1:0] cap;
  logic                last;

  dna_shift_capture u_cap (
    .clk_in   (CLK),
    .rst      (RST),
    .clr      (state == RD),
    .shift_en (state == SH),
    .din      (bus.DNA_DOUT),
    .cap      (cap),
    .last     (last)
  );

  // Recirculating leaves the primitive holding its original value after the read.
  assign bus.DNA_DIN = bus.DNA_DOUT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      pend          <= AUTO_START;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
      bus.DNA_VALID <= 1'b0;
      bus.DNA_VALUE <= '0;
      bus.DNA_MATCH <= 1'b0;
      bus.DNA_READ  <= 1'b0;
      bus.DNA_SHIFT <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        RD: begin
          state         <= SH;
          bus.DNA_READ  <= 1'b0;
          bus.DNA_SHIFT <= 1'b1;
        end
        SH: begin
          if (last) begin
            state         <= IDLE;
            bus.DNA_SHIFT <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b1;
            bus.DNA_VALID <= 1'b1;
            bus.DNA_VALUE <= cap;
            bus.DNA_MATCH <= dna_match(cap, EXPECTED_DNA, MATCH_MASK);
          end
        end
        default: begin
          // Encoding 2'd3 is treated exactly like IDLE.
          state         <= IDLE;
          bus.DNA_READ  <= 1'b0;
          bus.DNA_SHIFT <= 1'b0;
          bus.BUSY      <= 1'b0;
          if (bus.START || pend) begin
            state         <= RD;
            pend          <= 1'b0;
            bus.DNA_READ  <= 1'b1;
            bus.BUSY      <= 1'b1;
            bus.DNA_VALID <= 1'b0;
            bus.DNA_MATCH <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader_ctrl.sv
// Three reader instances (auto-start / exact-match / masked-match) against a DNA_PORTE2 model.
module tb_dna_reader_ctrl;
  import dna_pkg::*;

  localparam logic [95:0] SIM = 96'h0123456789ABCDEFFEDCBA98;
  localparam logic [95:0] B95 = {1'b1, 95'b0};
  localparam int          READ_CYCLES = DNA_BITS + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [95:0] sim_dna = SIM;
  bit          end_phase = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  task automatic check_bit(input int idx, input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL u%0d %s: got %b expected %b at %0t", idx, name, act, req, $time);
    end
  endtask

  task automatic check_vec(input int idx, input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL u%0d %s: got %h expected %h at %0t", idx, name, act, req, $time);
    end
  endtask

  task automatic check_int(input int idx, input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", idx, name, act, req, $time);
    end
  endtask

  // Bitwise reading of the compare rule: every masked bit must agree.
  function automatic bit ref_match(input logic [95:0] v, input logic [95:0] e, input logic [95:0] m);
    for (int i = 0; i < 96; i++)
      if (m[i] && (v[i] != e[i])) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam bit          AUTO = (gi == 0);
    localparam logic [95:0] EXP  = (gi == 0) ? SIM : (SIM ^ B95);
    localparam logic [95:0] MSK  = (gi == 2) ? ~B95 : {96{1'b1}};

    dna_reader_ctrl_if bus ();
    logic [95:0] sr = '0;

    assign bus.START    = start;
    assign bus.DNA_DOUT = sr[0];

    dna_reader_ctrl #(
      .AUTO_START   (AUTO),
      .EXPECTED_DNA (EXP),
      .MATCH_MASK   (MSK)
    ) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
    );

    // DNA_PORTE2 behaviour: READ loads, SHIFT moves right with DIN entering the MSB.
    always @(posedge CLK) begin
      if (bus.DNA_READ) sr <= sim_dna;
      else if (bus.DNA_SHIFT) sr <= {bus.DNA_DIN, sr[95:1]};
    end

    int          busy_left = 0;
    bit          pend = 1'b0;
    bit          exp_done = 1'b0;
    bit          exp_valid = 1'b0;
    logic [95:0] exp_val = '0;
    logic [95:0] cur_val = '0;
    logic [95:0] exp_q[$];
    int          n_reads = 0;
    int          n_dones = 0;
    int          shifts = 0;
    bit          final_done = 1'b0;

    // Reference model: a read occupies READ_CYCLES cycles from the accepting edge.
    initial forever begin
      @(posedge CLK);
      exp_done = 1'b0;
      if (RST) begin
        busy_left = 0;
        pend      = AUTO;
        exp_valid = 1'b0;
        exp_val   = '0;
        n_reads   = n_reads - exp_q.size();
        exp_q.delete();
      end else if (busy_left == 0) begin
        if (start || pend) begin
          busy_left = READ_CYCLES;
          pend      = 1'b0;
          exp_valid = 1'b0;
          cur_val   = sim_dna;
          exp_q.push_back(sim_dna);
          n_reads++;
        end
      end else begin
        busy_left--;
        if (busy_left == 0) begin
          exp_done  = 1'b1;
          exp_valid = 1'b1;
          exp_val   = cur_val;
        end
      end
    end

    initial forever begin
      logic [95:0] sb_val;
      @(negedge CLK);
      if (bus.DNA_READ) shifts = 0;
      if (bus.DNA_SHIFT) shifts++;
      check_bit(gi, "busy", bus.BUSY, busy_left > 0);
      check_bit(gi, "read", bus.DNA_READ, busy_left == READ_CYCLES);
      check_bit(gi, "shift", bus.DNA_SHIFT, (busy_left > 0) && (busy_left <= DNA_BITS));
      check_bit(gi, "done", bus.DONE, exp_done);
      check_bit(gi, "valid", bus.DNA_VALID, exp_valid);
      check_vec(gi, "value", bus.DNA_VALUE, exp_val);
      check_bit(gi, "match", bus.DNA_MATCH, exp_valid && ref_match(exp_val, EXP, MSK));
      if (bus.DONE === 1'b1) begin
        n_dones++;
        check_int(gi, "sb_queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          sb_val = exp_q.pop_front();
          check_vec(gi, "sb_value", bus.DNA_VALUE, sb_val);
          check_vec(gi, "port_recirculated", sr, sb_val);
          check_int(gi, "shift_count", shifts, DNA_BITS);
        end
      end
      if (end_phase && !final_done) begin
        final_done = 1'b1;
        check_int(gi, "sb_leftover", exp_q.size(), 0);
        check_int(gi, "done_count", n_dones, n_reads);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    cyc(2);
    RST = 1'b0;
    cyc(110);

    pulse_start();
    cyc(110);
    pulse_start();
    cyc(110);

    pulse_start();
    cyc(9);
    pulse_start();
    cyc(29);
    pulse_start();
    cyc(55);
    pulse_start();
    cyc(20);

    start = 1'b1;
    cyc(300);
    start = 1'b0;
    cyc(110);

    pulse_start();
    cyc(51);
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(110);
    pulse_start();
    cyc(110);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0:       sim_dna = SIM;
        1:       sim_dna = SIM ^ B95;
        default: sim_dna = {$urandom(), $urandom(), $urandom()};
      endcase
      pulse_start();
      repeat (3) begin
        cyc($urandom_range(1, 60));
        start = 1'b1;
        cyc($urandom_range(1, 4));
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        cyc($urandom_range(1, 90));
        RST = 1'b1;
        cyc($urandom_range(1, 3));
        RST = 1'b0;
      end
      cyc(110);
    end

    end_phase = 1'b1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
